// File: rtl/cam_miss_handler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cam_pkg
// Description : Shared types and helpers for the CAM miss handler.
//               - state_t         : miss-handler FSM state encoding
//               - TIMEOUT_DEFAULT : default memory-ack wait budget (cycles)
//               - sat_inc         : saturating increment for widths <= 32
// Revision    : 1.0 - initial release
// ============================================================================
package cam_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        MEM    = 3'd2,
        FILL   = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam int TIMEOUT_DEFAULT = 255;

    // Increment cur unless it already holds the all-ones value of a
    // width-bit counter. The 33-bit limit keeps width == 32 exact.
    function automatic logic [31:0] sat_inc(input logic [31:0] cur,
                                            input int unsigned width);
        logic [32:0] lim;
        lim = (33'd1 << width) - 33'd1;
        if ({1'b0, cur} >= lim) return cur;
        return cur + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cam_miss_handler_if.sv
`default_nettype none
// ============================================================================
// Module      : cam_miss_handler_if
// Description : Request/response bus between a requester and the CAM miss
//               handler.
//   req_valid/req_ready/req_tag          : lookup request handshake
//   rsp_valid/rsp_ready/rsp_data/
//   rsp_hit/rsp_err                      : response handshake and payload
//   master modport = requester, slave modport = miss handler
// Revision    : 1.0 - initial release
// ============================================================================
interface cam_miss_handler_if #(
    parameter int TAG_SZ = 8,
    parameter int BITS   = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [TAG_SZ-1:0] req_tag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [BITS-1:0]   rsp_data;
    logic              rsp_hit;
    logic              rsp_err;

    modport master (
        output req_valid, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_hit, rsp_err
    );

    modport slave (
        input  req_valid, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_hit, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/cam_miss_handler_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating event counter; holds at all-ones.
//   clk, rst_ : clock, asynchronous active-low reset
//   inc       : count one event this cycle
//   count     : current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import cam_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  wire              clk,
    input  wire              rst_,
    input  wire              inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc) count_d = CNT_W'(sat_inc(32'(count_q), CNT_W));
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;
endmodule
`default_nettype wire

// File: rtl/cam_miss_handler.sv
`default_nettype none
// ============================================================================
// Module      : cam_miss_handler
// Description : Lookup front-end and miss-fill controller for a tag CAM.
//               Probes the CAM, returns hit data, fetches misses from memory,
//               fills the CAM's first free slot and keeps hit/miss/drop stats.
//   clk, rst_      : clock, asynchronous active-low reset
//   bus (slave)    : request / response handshake
//   cam_*          : CAM probe (check_tag/read/data/found/full) and fill port
//   mem_*          : memory read request (level) with single-cycle ack
//   hit/miss/drop_cnt : saturating statistics
// Revision    : 1.0 - initial release
// ============================================================================
module cam_miss_handler
    import cam_pkg::*;
#(
    parameter int WORDS     = 8,
    parameter int BITS      = 8,
    parameter int TAG_SZ    = 8,
    parameter int ADDR_LEFT = $clog2(WORDS) - 1,
    parameter int TIMEOUT   = TIMEOUT_DEFAULT,
    parameter int CNT_W     = 16
) (
    input  wire                 clk,
    input  wire                 rst_,
    cam_miss_handler_if.slave   bus,
    output logic [TAG_SZ-1:0]   cam_check_tag,
    output logic                cam_read,
    input  wire  [BITS-1:0]     cam_data,
    input  wire                 cam_found,
    input  wire                 cam_full,
    output logic                cam_write_,
    output logic                cam_new_valid,
    output logic [TAG_SZ-1:0]   cam_new_tag,
    output logic [BITS-1:0]     cam_wdata,
    output logic [ADDR_LEFT:0]  cam_w_addr,
    output logic                mem_req,
    output logic [TAG_SZ-1:0]   mem_tag,
    input  wire                 mem_ack,
    input  wire  [BITS-1:0]     mem_data,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt,
    output logic [CNT_W-1:0]    drop_cnt
);
    localparam int             TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t            state_q,     state_d;
    logic [TAG_SZ-1:0] tag_q,       tag_d;
    logic [BITS-1:0]   data_q,      data_d;
    logic              hit_q,       hit_d;
    logic              err_q,       err_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              req_ready_q, req_ready_d;
    logic              cam_read_q,  cam_read_d;
    logic              mem_req_q,   mem_req_d;
    logic [TMO_W-1:0]  tmo_q,       tmo_d;
    logic              hit_inc, miss_inc, drop_inc;

    // Next-state logic; every handshake output is a flop loaded on the
    // transition into the state that owns it.
    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        data_d      = data_q;
        hit_d       = hit_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        req_ready_d = req_ready_q;
        cam_read_d  = cam_read_q;
        mem_req_d   = mem_req_q;
        tmo_d       = tmo_q;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        drop_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    tag_d       = bus.req_tag;
                    req_ready_d = 1'b0;
                    cam_read_d  = 1'b1;
                    state_d     = LOOKUP;
                end
            end
            LOOKUP: begin
                cam_read_d = 1'b0;
                if (cam_found) begin
                    data_d      = cam_data;
                    hit_d       = 1'b1;
                    hit_inc     = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    miss_inc  = 1'b1;
                    tmo_d     = '0;
                    mem_req_d = 1'b1;
                    state_d   = MEM;
                end
            end
            MEM: begin
                if (mem_ack) begin
                    data_d    = mem_data;
                    mem_req_d = 1'b0;
                    state_d   = FILL;
                end else if (tmo_q == TMO_LAST) begin
                    // Wait budget exhausted: answer with an error, no fill.
                    err_d       = 1'b1;
                    data_d      = '0;
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            FILL: begin
                drop_inc    = cam_full;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    hit_d       = 1'b0;
                    err_d       = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= IDLE;
            tag_q       <= '0;
            data_q      <= '0;
            hit_q       <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            cam_read_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            hit_q       <= hit_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            cam_read_q  <= cam_read_d;
            mem_req_q   <= mem_req_d;
            tmo_q       <= tmo_d;
        end
    end

    // The write strobe decodes the state flop directly so an asynchronous
    // reset during FILL withdraws it at once.
    assign cam_write_    = !((state_q == FILL) && !cam_full);
    assign cam_new_valid = (state_q == FILL) && !cam_full;
    assign cam_new_tag   = tag_q;
    assign cam_wdata     = data_q;
    assign cam_check_tag = tag_q;
    assign cam_read      = cam_read_q;
    assign cam_w_addr    = '0;
    assign mem_req       = mem_req_q;
    assign mem_tag       = tag_q;

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_hit   = hit_q;
    assign bus.rsp_err   = err_q;

    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt  (.clk(clk), .rst_(rst_), .inc(hit_inc),  .count(hit_cnt));
    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (.clk(clk), .rst_(rst_), .inc(miss_inc), .count(miss_cnt));
    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (.clk(clk), .rst_(rst_), .inc(drop_inc), .count(drop_cnt));
endmodule
`default_nettype wire

// File: tb/tb_cam_miss_handler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_miss_handler
// Description : Directed self-checking bench for cam_miss_handler with a
//               behavioural 8-entry CAM and a scripted memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_miss_handler;
    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic [7:0]  cam_check_tag, cam_data, cam_new_tag, cam_wdata, mem_tag, mem_data;
    logic        cam_read, cam_found, cam_full, cam_write_, cam_new_valid, mem_req, mem_ack;
    logic [2:0]  cam_w_addr;
    logic [15:0] hit_cnt, miss_cnt, drop_cnt;
    int          n_checks = 0;
    int          n_err = 0;

    cam_miss_handler_if #(.TAG_SZ(8), .BITS(8)) bus ();

    cam_miss_handler dut (
        .clk(clk), .rst_(rst_), .bus(bus),
        .cam_check_tag(cam_check_tag), .cam_read(cam_read), .cam_data(cam_data),
        .cam_found(cam_found), .cam_full(cam_full), .cam_write_(cam_write_),
        .cam_new_valid(cam_new_valid), .cam_new_tag(cam_new_tag), .cam_wdata(cam_wdata),
        .cam_w_addr(cam_w_addr), .mem_req(mem_req), .mem_tag(mem_tag), .mem_ack(mem_ack),
        .mem_data(mem_data), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural CAM: combinational match, fill into first free slot.
    logic       c_val [8];
    logic [7:0] c_tag [8];
    logic [7:0] c_dat [8];
    logic       cam_clear = 1'b1;
    int         wr_cnt = 0;
    logic [7:0] wr_tag = '0, wr_data = '0;
    logic       wr_valid = 1'b0;

    always_comb begin
        cam_found = 1'b0;
        cam_data  = '0;
        cam_full  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (c_val[i] && c_tag[i] == cam_check_tag) begin
                cam_found = 1'b1;
                cam_data  = c_dat[i];
            end
            if (!c_val[i]) cam_full = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (cam_clear) begin
            for (int i = 0; i < 8; i++) c_val[i] <= 1'b0;
        end else if (!cam_write_) begin
            wr_cnt   <= wr_cnt + 1;
            wr_tag   <= cam_new_tag;
            wr_data  <= cam_wdata;
            wr_valid <= cam_new_valid;
            begin : find_free
                for (int i = 0; i < 8; i++) begin
                    if (!c_val[i]) begin
                        c_val[i] <= cam_new_valid;
                        c_tag[i] <= cam_new_tag;
                        c_dat[i] <= cam_wdata;
                        disable find_free;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One request: ack_after = MEM cycle that carries mem_ack (0 = never).
    // hold = cycles rsp_ready stays low once rsp_valid is seen.
    task automatic txn(input logic [7:0] tag, input int ack_after, input logic [7:0] word,
                       input int hold, input logic [7:0] exp_data,
                       output logic [7:0] r_data, output logic r_hit, output logic r_err,
                       output int lat, output int mcyc);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_tag   = tag;
        bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat  = 0;
        mcyc = 0;
        while (!bus.rsp_valid && lat < 600) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req) begin
                mcyc++;
                if (ack_after != 0 && mcyc == ack_after) begin
                    mem_ack  = 1'b1;
                    mem_data = word;
                end
            end
            @(posedge clk); #1;
            lat++;
        end
        mem_ack = 1'b0;
        if (!bus.rsp_valid) chk("rsp_wait", {31'd0, bus.rsp_valid}, 32'd1);
        r_data = bus.rsp_data;
        r_hit  = bus.rsp_hit;
        r_err  = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_data", {24'd0, bus.rsp_data}, {24'd0, exp_data});
            chk("bp_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_done", {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    logic [7:0] d;
    logic       h, e;
    int         lat, mc, w0;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b0;
        mem_ack       = 1'b0;
        mem_data      = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset values
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_data",  {24'd0, bus.rsp_data}, 32'd0);
        chk("rst_mem_req",   {31'd0, mem_req}, 32'd0);
        chk("rst_cam_write", {31'd0, cam_write_}, 32'd1);
        chk("rst_cam_read",  {31'd0, cam_read}, 32'd0);
        chk("rst_cnts",      {hit_cnt, miss_cnt ^ drop_cnt}, 32'd0);
        chk("rst_waddr",     {29'd0, cam_w_addr}, 32'd0);
        @(negedge clk);
        rst_ = 1'b1;
        cam_clear = 1'b0;

        // Cold miss: ack on 4th MEM cycle
        txn(8'h3C, 4, 8'hA5, 0, 8'hA5, d, h, e, lat, mc);
        chk("cold_data", {24'd0, d}, 32'hA5);
        chk("cold_hit", {31'd0, h}, 32'd0);
        chk("cold_lat", lat, 6);
        chk("cold_wr_cnt", wr_cnt, 1);
        chk("cold_wr", {15'd0, wr_valid, wr_tag, wr_data}, {15'd0, 1'b1, 8'h3C, 8'hA5});
        chk("cold_miss_cnt", {16'd0, miss_cnt}, 32'd1);

        // Hit after fill
        txn(8'h3C, 0, 8'h00, 0, 8'hA5, d, h, e, lat, mc);
        chk("hit_data", {24'd0, d}, 32'hA5);
        chk("hit_hit", {31'd0, h}, 32'd1);
        chk("hit_lat", lat, 1);
        chk("hit_no_mem", mc, 0);
        chk("hit_cnt", {16'd0, hit_cnt}, 32'd1);

        // Timeout: no ack ever
        w0 = wr_cnt;
        txn(8'h55, 0, 8'h00, 0, 8'h00, d, h, e, lat, mc);
        chk("tmo_mem_cycles", mc, 255);
        chk("tmo_lat", lat, 256);
        chk("tmo_err", {31'd0, e}, 32'd1);
        chk("tmo_data", {24'd0, d}, 32'd0);
        chk("tmo_no_write", wr_cnt, w0);
        chk("tmo_err_clr", {31'd0, bus.rsp_err}, 32'd0);

        // Backpressure on a hit
        txn(8'h3C, 0, 8'h00, 10, 8'hA5, d, h, e, lat, mc);
        chk("bp_hit", {31'd0, h}, 32'd1);
        chk("bp_hit_cnt", {16'd0, hit_cnt}, 32'd2);

        // Fill remaining 7 slots
        for (int i = 0; i < 7; i++) begin
            txn(8'h10 + 8'(i), 1, 8'h80 + 8'(i), 0, 8'h80 + 8'(i), d, h, e, lat, mc);
            chk("fill_data", {24'd0, d}, {24'd0, 8'h80 + 8'(i)});
        end
        chk("fill_lat", lat, 3);
        chk("fill_wr_cnt", wr_cnt, 8);
        chk("fill_miss_cnt", {16'd0, miss_cnt}, 32'd9);

        // CAM full: ninth tag is returned but dropped
        txn(8'h77, 2, 8'h11, 0, 8'h11, d, h, e, lat, mc);
        chk("full_data", {24'd0, d}, 32'h11);
        chk("full_no_write", wr_cnt, 8);
        chk("full_drop_cnt", {16'd0, drop_cnt}, 32'd1);
        txn(8'h77, 1, 8'h22, 0, 8'h22, d, h, e, lat, mc);
        chk("full_remiss_hit", {31'd0, h}, 32'd0);
        chk("full_remiss_mem", {31'd0, mc > 0}, 32'd1);
        chk("full_remiss_data", {24'd0, d}, 32'h22);
        chk("full_miss_cnt", {16'd0, miss_cnt}, 32'd11);
        chk("full_drop_cnt2", {16'd0, drop_cnt}, 32'd2);

        // Reset during MEM, then a late ack
        @(negedge clk);
        cam_clear = 1'b1;
        @(negedge clk);
        cam_clear = 1'b0;
        w0 = wr_cnt;
        bus.req_valid = 1'b1;
        bus.req_tag   = 8'h66;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int i = 0; i < 20 && !mem_req; i++) begin
            @(posedge clk); #1;
        end
        chk("rmid_mem_req_up", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        rst_ = 1'b0;
        #1;
        chk("rmid_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rmid_cnts", {hit_cnt, miss_cnt | drop_cnt}, 32'd0);
        chk("rmid_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        mem_ack  = 1'b1;
        mem_data = 8'hEE;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rmid_no_write", wr_cnt, w0);
        chk("rmid_idle_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rmid_idle_mem", {31'd0, mem_req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
